// File: rtl/spi_slave_control.sv
// spi_slave_control: SPI mode-3 slave with synchronized pins,
// a 1..4 byte transmit word and a 4-byte receive packing register.
module spi_slave_control #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        MISO_IDLE   = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        spi_clk_i,
    input  logic        spi_cs_n_i,
    input  logic        spi_mosi_i,
    output logic        spi_miso_o,
    input  logic [31:0] tx_data_i,
    input  logic [2:0]  tx_bytes_valid_i,
    input  logic        tx_load_i,
    output logic        tx_ready_o,
    output logic [31:0] rx_data_o,
    output logic [2:0]  rx_bytes_valid_o,
    output logic        rx_byte_strobe_o,
    input  logic        rx_clear_i,
    output logic        busy_o
);
    typedef enum logic {IDLE, ACTIVE} state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic sclk_prev_q, sclk_prev_d;
    logic cs_prev_q, cs_prev_d;

    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [31:0] tx_data_q, tx_data_d;
    logic [2:0]  tx_rem_q, tx_rem_d;
    logic        miso_q, miso_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic [31:0] rx_data_q, rx_data_d;
    logic [2:0]  rx_fill_q, rx_fill_d;
    logic        rx_stb_q, rx_stb_d;

    logic       sclk_s, cs_s, mosi_s;
    logic       sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [2:0] tx_n_in;
    logic [1:0] tx_ptr;
    logic [1:0] rx_slot;
    logic [7:0] rx_byte;
    logic       byte_done;

    // Synchronizer chains and edge-detect history
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_clk_i};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n_i};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
        sclk_s      = sclk_sync_q[SYNC_STAGES-1];
        cs_s        = cs_sync_q[SYNC_STAGES-1];
        mosi_s      = mosi_sync_q[SYNC_STAGES-1];
        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_s;
        sclk_rise   = sclk_s & ~sclk_prev_q;
        sclk_fall   = ~sclk_s & sclk_prev_q;
        cs_rise     = cs_s & ~cs_prev_q;
        cs_fall     = ~cs_s & cs_prev_q;
    end

    // Synchronizer registers; reset to bus idle levels
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclk_sync_q <= '1;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b1;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
        end
    end

    // Next state, shift/tx datapath and rx packing
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        tx_data_d  = tx_data_q;
        tx_rem_d   = tx_rem_q;
        miso_d     = miso_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_fill_d  = rx_fill_q;
        rx_stb_d   = 1'b0;
        byte_done  = 1'b0;
        tx_n_in    = (tx_bytes_valid_i > 3'd4) ? 3'd4 : tx_bytes_valid_i;
        tx_ptr     = tx_rem_q[1:0] - 2'd1;
        rx_byte    = {rx_shift_q[6:0], mosi_s};

        unique case (state_q)
            IDLE: begin
                if (tx_load_i) begin
                    tx_data_d = tx_data_i;
                    tx_rem_d  = tx_n_in;
                end
                if (cs_fall) begin
                    state_d    = ACTIVE;
                    bit_cnt_d  = 3'd7;
                    rx_shift_d = 8'h00;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_d    = IDLE;
                    bit_cnt_d  = 3'd7;
                    tx_rem_d   = 3'd0;
                    miso_d     = MISO_IDLE;
                    rx_shift_d = 8'h00;
                end else if (sclk_fall) begin
                    if (tx_rem_q == 3'd0) miso_d = MISO_IDLE;
                    else miso_d = tx_data_q[{tx_ptr, bit_cnt_q}];
                end else if (sclk_rise) begin
                    rx_shift_d = rx_byte;
                    bit_cnt_d  = bit_cnt_q - 3'd1;
                    if (bit_cnt_q == 3'd0) begin
                        byte_done = 1'b1;
                        if (tx_rem_q != 3'd0) tx_rem_d = tx_rem_q - 3'd1;
                    end
                end
            end
        endcase

        // A full register wraps back to the top byte
        rx_slot = rx_fill_q[1:0];
        if (rx_clear_i) begin
            rx_data_d = 32'h0;
            rx_fill_d = 3'd0;
            rx_slot   = 2'd0;
        end
        if (byte_done) begin
            rx_stb_d = 1'b1;
            rx_data_d[{~rx_slot, 3'b000} +: 8] = rx_byte;
            rx_fill_d = {1'b0, rx_slot} + 3'd1;
        end
    end

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else state_q <= state_d;
    end

    // Datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bit_cnt_q  <= 3'd7;
            tx_data_q  <= 32'h0;
            tx_rem_q   <= 3'd0;
            miso_q     <= MISO_IDLE;
            rx_shift_q <= 8'h00;
            rx_data_q  <= 32'h0;
            rx_fill_q  <= 3'd0;
            rx_stb_q   <= 1'b0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            tx_data_q  <= tx_data_d;
            tx_rem_q   <= tx_rem_d;
            miso_q     <= miso_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_fill_q  <= rx_fill_d;
            rx_stb_q   <= rx_stb_d;
        end
    end

    assign spi_miso_o       = miso_q;
    assign tx_ready_o       = (state_q == IDLE);
    assign busy_o           = (state_q == ACTIVE);
    assign rx_data_o        = rx_data_q;
    assign rx_bytes_valid_o = rx_fill_q;
    assign rx_byte_strobe_o = rx_stb_q;
endmodule

// File: tb/tb_spi_slave_control.sv
// tb_spi_slave_control: directed + random SPI mode-3 transfers
// checked against a byte-level model of the slave.
module tb_spi_slave_control;
    localparam int   SS = 2;
    localparam logic MI = 1'b1;
    localparam int   PH = 8;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        spi_clk_i = 1'b1;
    logic        spi_cs_n_i = 1'b1;
    logic        spi_mosi_i = 1'b0;
    logic        spi_miso_o;
    logic [31:0] tx_data_i = 32'h0;
    logic [2:0]  tx_bytes_valid_i = 3'd0;
    logic        tx_load_i = 1'b0;
    logic        tx_ready_o;
    logic [31:0] rx_data_o;
    logic [2:0]  rx_bytes_valid_o;
    logic        rx_byte_strobe_o;
    logic        rx_clear_i = 1'b0;
    logic        busy_o;

    spi_slave_control #(.SYNC_STAGES(SS), .MISO_IDLE(MI)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .spi_clk_i(spi_clk_i), .spi_cs_n_i(spi_cs_n_i),
        .spi_mosi_i(spi_mosi_i), .spi_miso_o(spi_miso_o),
        .tx_data_i(tx_data_i), .tx_bytes_valid_i(tx_bytes_valid_i),
        .tx_load_i(tx_load_i), .tx_ready_o(tx_ready_o),
        .rx_data_o(rx_data_o), .rx_bytes_valid_o(rx_bytes_valid_o),
        .rx_byte_strobe_o(rx_byte_strobe_o), .rx_clear_i(rx_clear_i),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int stb_cnt = 0;

    // Model state: rx bytes indexed by position from the top, tx word
    logic [7:0]  m_rx [4];
    int          m_fill;
    logic [31:0] m_tx;
    int          m_txn;

    always @(negedge clk_i) if (rx_byte_strobe_o) stb_cnt++;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_rx_word();
        return {m_rx[0], m_rx[1], m_rx[2], m_rx[3]};
    endfunction

    function automatic void m_rx_reset();
        for (int j = 0; j < 4; j++) m_rx[j] = 8'h00;
        m_fill = 0;
    endfunction

    function automatic void m_rx_push(input logic [7:0] b);
        int s;
        s = m_fill % 4;
        m_rx[s] = b;
        m_fill = s + 1;
    endfunction

    function automatic logic m_miso_bit(input int i);
        logic [31:0] w;
        int idx;
        w = m_tx;
        if (i < 8 * m_txn) begin
            idx = 8 * (m_txn - 1 - i / 8) + 7 - (i % 8);
            return w[idx];
        end
        return MI;
    endfunction

    task automatic load(input logic [31:0] w, input int n);
        @(negedge clk_i);
        chk("load_ready", tx_ready_o, 1);
        tx_data_i = w;
        tx_bytes_valid_i = n[2:0];
        tx_load_i = 1'b1;
        @(negedge clk_i);
        tx_load_i = 1'b0;
        m_tx = w;
        m_txn = (n > 4) ? 4 : n;
    endtask

    task automatic rx_clear_idle();
        @(negedge clk_i);
        rx_clear_i = 1'b1;
        @(negedge clk_i);
        rx_clear_i = 1'b0;
        m_rx_reset();
        chk("clr_data", rx_data_o, 0);
        chk("clr_fill", rx_bytes_valid_o, 0);
    endtask

    // Master: stop_bit >= 0 ends after that bit (abort or reset)
    task automatic xfer(input string tag, input int nbits,
                        input logic [63:0] mosi, input int clr_bit,
                        input int load_bit, input int stop_bit,
                        input bit do_rst);
        logic [63:0] cap, exp;
        logic [7:0] b;
        int s0, nbytes, nb, n;
        cap = '0; exp = '0; nbytes = 0; nb = 0;
        s0 = stb_cnt;
        @(negedge clk_i);
        spi_cs_n_i = 1'b0;
        repeat (PH) @(negedge clk_i);
        chk({tag, "_busy"}, {busy_o, tx_ready_o}, 2'b10);
        for (int i = 0; i < nbits; i++) begin
            spi_clk_i = 1'b0;
            spi_mosi_i = mosi[nbits - 1 - i];
            for (int k = 1; k <= PH; k++) begin
                @(negedge clk_i);
                tx_load_i = (i == load_bit && k == 2);
                if (i == load_bit && k == 2) begin
                    tx_data_i = 32'hFFFF_FFFF;
                    tx_bytes_valid_i = 3'd4;
                end
            end
            cap = {cap[62:0], spi_miso_o};
            exp = {exp[62:0], m_miso_bit(i)};
            nb++;
            spi_clk_i = 1'b1;
            for (int k = 1; k <= PH; k++) begin
                @(negedge clk_i);
                rx_clear_i = (i == clr_bit && k == SS);
            end
            if (i % 8 == 7) begin
                b = 8'(mosi >> (nbits - 1 - i));
                if (i == clr_bit) m_rx_reset();
                m_rx_push(b);
                nbytes++;
                chk({tag, "_rxdata"}, rx_data_o, m_rx_word());
                chk({tag, "_rxfill"}, rx_bytes_valid_o, m_fill);
            end
            if (i == stop_bit) begin
                if (do_rst) begin
                    rst_i = 1'b1;
                    @(negedge clk_i);
                    rst_i = 1'b0;
                    chk({tag, "_rst_outs"},
                        {spi_miso_o, tx_ready_o, busy_o, rx_byte_strobe_o,
                         rx_bytes_valid_o, rx_data_o},
                        {MI, 1'b1, 1'b0, 1'b0, 3'd0, 32'd0});
                    m_rx_reset();
                    m_txn = 0;
                end
                break;
            end
        end
        @(negedge clk_i);
        spi_cs_n_i = 1'b1;
        n = 0;
        while (!tx_ready_o && n < 10) begin
            @(negedge clk_i);
            n++;
        end
        chk({tag, "_rdy_lat"}, (tx_ready_o && n <= SS + 2), 1);
        m_txn = 0;
        repeat (4) @(negedge clk_i);
        chk({tag, "_idle"}, {busy_o, spi_miso_o}, {1'b0, MI});
        chk({tag, "_miso"}, cap, exp);
        chk({tag, "_nstb"}, stb_cnt - s0, nbytes);
        chk({tag, "_rxkeep"}, {rx_bytes_valid_o, rx_data_o},
            {3'(m_fill), m_rx_word()});
    endtask

    initial begin
        logic [63:0] r;
        int nb, n, cb;
        m_rx_reset();
        m_tx = 32'h0;
        m_txn = 0;
        repeat (4) @(negedge clk_i);
        chk("reset_outs",
            {spi_miso_o, tx_ready_o, busy_o, rx_byte_strobe_o,
             rx_bytes_valid_o, rx_data_o},
            {MI, 1'b1, 1'b0, 1'b0, 3'd0, 32'd0});
        rst_i = 1'b0;
        repeat (4) @(negedge clk_i);

        load(32'h00A5_3CC3, 2);
        xfer("t16", 16, 64'h1234, -1, -1, -1, 1'b0);
        chk("t16_data", rx_data_o, 32'h1234_0000);
        chk("t16_fill", rx_bytes_valid_o, 2);

        rx_clear_idle();
        r = {$urandom, $urandom};
        load($urandom, 2);
        xfer("t40", 40, r, -1, -1, -1, 1'b0);
        chk("t40_top", rx_data_o[31:24], r[7:0]);

        xfer("tclr", 16, 64'($urandom), 15, -1, -1, 1'b0);
        chk("tclr_fill", rx_bytes_valid_o, 1);

        load($urandom, 4);
        xfer("tload", 32, 64'($urandom), -1, 5, -1, 1'b0);

        load($urandom, 3);
        xfer("tabort", 16, 64'($urandom), -1, -1, 4, 1'b0);
        xfer("tempty", 8, 64'($urandom), -1, -1, -1, 1'b0);

        load($urandom, 1);
        xfer("trst", 8, 64'($urandom), -1, -1, 2, 1'b1);
        load($urandom, 1);
        xfer("tpost", 8, 64'($urandom), -1, -1, -1, 1'b0);

        for (int t = 0; t < 6; t++) begin
            nb = 8 * $urandom_range(1, 5);
            n = $urandom_range(0, 7);
            cb = ($urandom_range(0, 2) == 0) ? 8 * $urandom_range(1, nb / 8) - 1 : -1;
            r = {$urandom, $urandom};
            load($urandom, n);
            xfer("trand", nb, r, cb, -1, -1, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
